qid_measfb_queue: RTL

Measurement-feedback queue for the QID stage. It accepts per-measurement basis-selection results from the logical measurement return path and holds them in arrival order. It presents the oldest one to the QID decoder as `measfb_xorz`, and retires it when the decoder reports `a_taken`, which marks a feedback-dependent `LQM_FB` instruction resolved to `LQM_X`/`LQM_Z`. It is the producing end of the decoder's `measfb_xorz`/`a_taken` interface.

---
 rtl/qid_measfb_queue_if.sv | 26 ++
 rtl/qid_measfb_queue.sv | 90 +++++++++
 2 files changed

// File: rtl/qid_measfb_queue_if.sv
// Handshake bundle between the measurement return path, the QID decoder and the
// measurement-feedback queue.
interface qid_measfb_queue_if #(
  parameter int PTR_BW = 2
);
  logic              fb_valid;
  logic [1:0]        fb_xorz;
  logic              fb_ready;
  logic              flush;
  logic              a_taken;
  logic [1:0]        measfb_xorz;
  logic [PTR_BW:0]   fb_count;
  logic              empty;
  logic              full;
  logic [2:0]        err;

  modport slave (
    input  fb_valid, fb_xorz, flush, a_taken,
    output fb_ready, measfb_xorz, fb_count, empty, full, err
  );

  modport master (
    output fb_valid, fb_xorz, flush, a_taken,
    input  fb_ready, measfb_xorz, fb_count, empty, full, err
  );
endinterface

// File: rtl/qid_measfb_queue.sv
// In-order queue of X/Z basis results feeding the QID decoder; the head entry is
// retired when the decoder resolves a feedback-dependent measurement.
module qid_measfb_queue #(
  parameter int DEPTH  = 4,
  parameter int PTR_BW = 2
) (
  input  logic               clk,
  input  logic               rst,
  qid_measfb_queue_if.slave  bus
);
  localparam logic [1:0]      PP_I     = 2'b00;
  localparam logic [1:0]      PP_X     = 2'b01;
  localparam logic [1:0]      PP_Z     = 2'b10;
  localparam logic [PTR_BW:0] CNT_FULL = (PTR_BW + 1)'(DEPTH);

  logic [1:0]        r_mem [DEPTH];
  logic [PTR_BW-1:0] r_wr_ptr;
  logic [PTR_BW-1:0] r_rd_ptr;
  logic [PTR_BW:0]   r_count;
  logic [2:0]        r_err;

  logic w_legal;
  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_legal = (bus.fb_xorz == PP_X) || (bus.fb_xorz == PP_Z);
  assign w_full  = (r_count == CNT_FULL);
  assign w_empty = (r_count == '0);

  // Accept/retire decisions use occupancy from the start of the cycle, so a
  // same-cycle pop never frees space for a push into a full queue.
  assign w_push = bus.fb_valid && w_legal && !w_full && !bus.flush;
  assign w_pop  = bus.a_taken && !w_empty && !bus.flush;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.fb_xorz;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (bus.flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_BW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_BW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_BW + 1)'(1);
        2'b01:   r_count <= r_count - (PTR_BW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Error flags are sticky until reset and reflect the request, independent of flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 3'b000;
    end else begin
      if (bus.fb_valid && w_legal && w_full) begin
        r_err[0] <= 1'b1;
      end
      if (bus.a_taken && w_empty) begin
        r_err[1] <= 1'b1;
      end
      if (bus.fb_valid && !w_legal) begin
        r_err[2] <= 1'b1;
      end
    end
  end

  assign bus.fb_count    = r_count;
  assign bus.empty       = w_empty;
  assign bus.full        = w_full;
  assign bus.fb_ready    = !w_full;
  assign bus.err         = r_err;
  assign bus.measfb_xorz = w_empty ? PP_I : r_mem[r_rd_ptr];
endmodule
